// File: rtl/microbenchmark_pkg.sv
// Shared definitions for the microbenchmark CSR block: register map, MODE bit
// positions, AXI response codes and the run-state encoding.
package microbenchmark_pkg;

    localparam int unsigned OFF_CTRL     = 'h00;
    localparam int unsigned OFF_STATUS   = 'h08;
    localparam int unsigned OFF_NUM_REQ  = 'h10;
    localparam int unsigned OFF_BOUND    = 'h18;
    localparam int unsigned OFF_REQ_SIZE = 'h20;
    localparam int unsigned OFF_STRIDE   = 'h28;
    localparam int unsigned OFF_MODE     = 'h30;
    localparam int unsigned OFF_CYCLES   = 'h38;
    localparam int unsigned OFF_BASE     = 'h40;

    localparam int MODE_ACCESS_PATTERN = 0;
    localparam int MODE_INDEPENDENT    = 1;
    localparam int MODE_PTR            = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [3:0] {
        RK_CTRL,
        RK_STATUS,
        RK_NUM_REQ,
        RK_BOUND,
        RK_REQ_SIZE,
        RK_STRIDE,
        RK_MODE,
        RK_CYCLES,
        RK_BASE,
        RK_NONE
    } reg_kind_t;

endpackage

// File: rtl/microbenchmark_csr_ctrl_axil_wr_slave.sv
// AXI4-Lite write front end: latches AW and W independently, then presents a
// single-cycle wr_en with the captured address/data/strobe and answers on B.
module axil_wr_slave
    import microbenchmark_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 64
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   axil_awvalid,
    output logic                   axil_awready,
    input  logic [ADDR_BITS-1:0]   axil_awaddr,
    input  logic                   axil_wvalid,
    output logic                   axil_wready,
    input  logic [DATA_BITS-1:0]   axil_wdata,
    input  logic [DATA_BITS/8-1:0] axil_wstrb,
    output logic                   axil_bvalid,
    input  logic                   axil_bready,
    output logic [1:0]             axil_bresp,
    output logic                   wr_en,
    output logic [ADDR_BITS-1:0]   wr_addr,
    output logic [DATA_BITS-1:0]   wr_data,
    output logic [DATA_BITS/8-1:0] wr_strb,
    input  logic                   wr_err
);

    // Handshake rule on every channel: a beat transfers on the rising edge where
    // valid && ready; the source keeps valid and payload stable until that edge,
    // and each ready here depends only on registered local state.
    logic aw_held;
    logic w_held;

    assign wr_en = aw_held && w_held && !axil_bvalid;

    always_ff @(posedge aclk) begin
        if (areset) begin
            axil_awready <= 1'b1;
            axil_wready  <= 1'b1;
            axil_bvalid  <= 1'b0;
            axil_bresp   <= RESP_OKAY;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_strb      <= '0;
        end else begin
            if (axil_awvalid && axil_awready) begin
                wr_addr      <= axil_awaddr;
                aw_held      <= 1'b1;
                axil_awready <= 1'b0;
            end
            if (axil_wvalid && axil_wready) begin
                wr_data     <= axil_wdata;
                wr_strb     <= axil_wstrb;
                w_held      <= 1'b1;
                axil_wready <= 1'b0;
            end
            if (wr_en) begin
                axil_bvalid <= 1'b1;
                axil_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
                aw_held     <= 1'b0;
                w_held      <= 1'b0;
            end
            // Both readies stay low for the whole transaction, reopening only
            // once the response has been taken.
            if (axil_bvalid && axil_bready) begin
                axil_bvalid  <= 1'b0;
                axil_awready <= 1'b1;
                axil_wready  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/microbenchmark_csr_ctrl.sv
// AXI4-Lite CSR file for the microbenchmark engine: config registers, per-channel
// base addresses, start/done tracking via an IDLE/RUN FSM and a run-cycle counter.
module microbenchmark_csr_ctrl
    import microbenchmark_pkg::*;
#(
    parameter int N_CH      = 16,
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 12
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            axil_awvalid,
    output logic                            axil_awready,
    input  logic [ADDR_BITS-1:0]            axil_awaddr,
    input  logic                            axil_wvalid,
    output logic                            axil_wready,
    input  logic [DATA_BITS-1:0]            axil_wdata,
    input  logic [DATA_BITS/8-1:0]          axil_wstrb,
    output logic                            axil_bvalid,
    input  logic                            axil_bready,
    output logic [1:0]                      axil_bresp,
    input  logic                            axil_arvalid,
    output logic                            axil_arready,
    input  logic [ADDR_BITS-1:0]            axil_araddr,
    output logic                            axil_rvalid,
    input  logic                            axil_rready,
    output logic [DATA_BITS-1:0]            axil_rdata,
    output logic [1:0]                      axil_rresp,
    output logic [DATA_BITS-1:0]            num_requests,
    output logic [DATA_BITS-1:0]            bound,
    output logic [DATA_BITS-1:0]            req_size,
    output logic [DATA_BITS-1:0]            stride,
    output logic [N_CH-1:0][DATA_BITS-1:0]  base_addr,
    output logic                            access_pattern,
    output logic                            independent,
    output logic                            ptr,
    output logic [N_CH-1:0]                 ch_start,
    input  logic [N_CH-1:0]                 ch_done,
    output state_t                          fsm_state
);

    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int STROBES = DATA_BITS / 8;

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic [STROBES-1:0]   wr_strb;
    logic                 wr_err;
    logic                 wr_ok;
    reg_kind_t            wr_kind;
    int unsigned          wr_base;
    logic [DATA_BITS-1:0] wmask;

    state_t               state;
    state_t               state_n;
    logic [2:0]           mode_q;
    logic [DATA_BITS-1:0] cycles;
    logic [N_CH-1:0]      active_mask;
    logic [N_CH-1:0]      new_active;
    logic [N_CH-1:0]      done_mask;
    logic [N_CH-1:0]      done_next;
    logic                 done;
    logic                 busy;
    logic                 start_go;
    logic                 accept_done;
    logic                 run_complete;
    logic [CH_W-1:0]      last_ch;
    logic [N_CH+1:0]      status_w;

    reg_kind_t            rd_kind;
    logic [DATA_BITS-1:0] rd_value;
    logic                 rd_err;

    // The low three address bits are ignored: every register is 8 bytes wide.
    function automatic reg_kind_t decode(input logic [ADDR_BITS-1:0] a);
        int unsigned off;
        off = 32'(a) & ~32'h7;
        case (off)
            OFF_CTRL:     return RK_CTRL;
            OFF_STATUS:   return RK_STATUS;
            OFF_NUM_REQ:  return RK_NUM_REQ;
            OFF_BOUND:    return RK_BOUND;
            OFF_REQ_SIZE: return RK_REQ_SIZE;
            OFF_STRIDE:   return RK_STRIDE;
            OFF_MODE:     return RK_MODE;
            OFF_CYCLES:   return RK_CYCLES;
            default: begin
                if (off >= OFF_BASE && off < OFF_BASE + 32'(8 * N_CH)) return RK_BASE;
                return RK_NONE;
            end
        endcase
    endfunction

    function automatic int unsigned base_idx(input logic [ADDR_BITS-1:0] a);
        return (32'(a) - OFF_BASE) >> 3;
    endfunction

    function automatic logic [DATA_BITS-1:0] merge(input logic [DATA_BITS-1:0] old_v,
                                                   input logic [DATA_BITS-1:0] new_v,
                                                   input logic [DATA_BITS-1:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    axil_wr_slave #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_wr (
        .aclk         (aclk),
        .areset       (areset),
        .axil_awvalid (axil_awvalid),
        .axil_awready (axil_awready),
        .axil_awaddr  (axil_awaddr),
        .axil_wvalid  (axil_wvalid),
        .axil_wready  (axil_wready),
        .axil_wdata   (axil_wdata),
        .axil_wstrb   (axil_wstrb),
        .axil_bvalid  (axil_bvalid),
        .axil_bready  (axil_bready),
        .axil_bresp   (axil_bresp),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .wr_err       (wr_err)
    );

    assign busy           = (state == ST_RUN);
    assign status_w       = {done_mask, done, busy};
    assign access_pattern = mode_q[MODE_ACCESS_PATTERN];
    assign independent    = mode_q[MODE_INDEPENDENT];
    assign ptr            = mode_q[MODE_PTR];
    assign fsm_state      = state;
    assign last_ch        = wr_data[CH_W:1];

    always_comb begin : wr_decode
        wr_kind  = decode(wr_addr);
        wr_base  = base_idx(wr_addr);
        wr_err   = (state == ST_RUN) || (wr_kind inside {RK_STATUS, RK_CYCLES, RK_NONE});
        wr_ok    = wr_en && !wr_err;
        start_go = wr_ok && (wr_kind == RK_CTRL) && wr_data[0];
        wmask    = '0;
        for (int i = 0; i < STROBES; i++) wmask[8*i +: 8] = {8{wr_strb[i]}};
        new_active = '0;
        for (int i = 0; i < N_CH; i++) new_active[i] = (32'(i) <= 32'(last_ch));
    end

    // A done pulse that coincides with the start pulse belongs to a previous run.
    always_comb begin : fsm_next
        accept_done  = (state == ST_RUN) && (ch_start == '0);
        done_next    = done_mask | (accept_done ? (ch_done & active_mask) : '0);
        run_complete = (state == ST_RUN) && ((done_next & active_mask) == active_mask);
        state_n      = state;
        case (state)
            ST_IDLE: if (start_go)     state_n = ST_RUN;
            ST_RUN:  if (run_complete) state_n = ST_IDLE;
            default:                   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            num_requests <= '0;
            bound        <= '0;
            req_size     <= '0;
            stride       <= '0;
            base_addr    <= '0;
            mode_q       <= '0;
            cycles       <= '0;
            active_mask  <= '0;
            done_mask    <= '0;
            done         <= 1'b0;
            ch_start     <= '0;
        end else begin
            ch_start <= '0;
            if (wr_ok) begin
                case (wr_kind)
                    RK_NUM_REQ:  num_requests <= merge(num_requests, wr_data, wmask);
                    RK_BOUND:    bound        <= merge(bound, wr_data, wmask);
                    RK_REQ_SIZE: req_size     <= merge(req_size, wr_data, wmask);
                    RK_STRIDE:   stride       <= merge(stride, wr_data, wmask);
                    RK_MODE:     mode_q       <= (mode_q & ~wmask[2:0]) | (wr_data[2:0] & wmask[2:0]);
                    RK_BASE: begin
                        for (int k = 0; k < N_CH; k++)
                            if (32'(k) == wr_base) base_addr[k] <= merge(base_addr[k], wr_data, wmask);
                    end
                    default: ;
                endcase
            end
            if (start_go) begin
                active_mask <= new_active;
                ch_start    <= new_active;
                done_mask   <= '0;
                cycles      <= '0;
                done        <= 1'b0;
            end else if (state == ST_RUN) begin
                done_mask <= done_next;
                if (cycles != '1) cycles <= cycles + 1'b1;
                if (run_complete) done <= 1'b1;
            end
        end
    end

    always_comb begin : rd_mux
        rd_kind  = decode(axil_araddr);
        rd_value = '0;
        rd_err   = 1'b0;
        case (rd_kind)
            RK_STATUS:   rd_value = DATA_BITS'(status_w);
            RK_NUM_REQ:  rd_value = num_requests;
            RK_BOUND:    rd_value = bound;
            RK_REQ_SIZE: rd_value = req_size;
            RK_STRIDE:   rd_value = stride;
            RK_MODE:     rd_value = DATA_BITS'(mode_q);
            RK_CYCLES:   rd_value = cycles;
            RK_BASE: begin
                for (int k = 0; k < N_CH; k++)
                    if (32'(k) == base_idx(axil_araddr)) rd_value = base_addr[k];
            end
            default:     rd_err = 1'b1;
        endcase
    end

    // Read data is captured at the AR handshake, so a same-cycle write is not seen.
    always_ff @(posedge aclk) begin
        if (areset) begin
            axil_arready <= 1'b1;
            axil_rvalid  <= 1'b0;
            axil_rdata   <= '0;
            axil_rresp   <= RESP_OKAY;
        end else begin
            if (axil_arvalid && axil_arready) begin
                axil_arready <= 1'b0;
                axil_rvalid  <= 1'b1;
                axil_rdata   <= rd_value;
                axil_rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (axil_rvalid && axil_rready) begin
                axil_rvalid  <= 1'b0;
                axil_arready <= 1'b1;
            end
        end
    end

endmodule
